x_oneshot_array: RTL

Parametrised multi-channel digital one-shot with a programmable deadtime and a selectable re-arm mode. Each channel emits a registered 1-clock pulse on a qualifying rising of its input, then holds off re-triggering until its deadtime has expired. Depending on mode, it also waits for the input to return low. It sits between the S-bit/cluster input stage and downstream cluster logic, and replaces per-channel single-bit one-shot instances. A registered count of channels fired per cycle is provided for rate monitoring.

---
 rtl/x_oneshot_array.sv | 96 +++++++++
 1 files changed

// File: rtl/x_oneshot_array.sv
// x_oneshot_array: multi-channel one-shot with shared programmable deadtime,
// level/retrigger re-arm modes and a registered fired-channel count.
module x_oneshot_array #(
   parameter int NCH     = 8,
   parameter int DTBITS  = 4,
   parameter int CNTBITS = $clog2(NCH + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NCH-1:0]     d,
   input  logic [NCH-1:0]     mask_i,
   input  logic [DTBITS-1:0]  deadtime_i,
   input  logic               mode_i,
   output logic [NCH-1:0]     q,
   output logic [NCH-1:0]     busy,
   output logic [CNTBITS-1:0] q_cnt
);

   // one-hot encoding so the two all-zero/all-one codes fall back to IDLE
   localparam logic [1:0] S_IDLE = 2'b01;
   localparam logic [1:0] S_HOLD = 2'b10;

   logic [1:0]         r_state [NCH];
   logic [1:0]         w_next  [NCH];
   logic [DTBITS-1:0]  r_cnt   [NCH];
   logic [NCH-1:0]     w_trig;
   logic [NCH-1:0]     w_rel;
   logic [NCH-1:0]     w_busy;
   logic [NCH-1:0]     r_q;
   logic [DTBITS-1:0]  r_dt;
   logic               r_mode;
   logic [CNTBITS-1:0] r_qcnt;
   logic [CNTBITS-1:0] w_pop;

   always_ff @(posedge clock) begin
      for (int i = 0; i < NCH; i++) begin
         if (reset) r_state[i] <= S_IDLE;
         else       r_state[i] <= w_next[i];
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         w_next[i] = S_IDLE;
         case (r_state[i])
            S_IDLE:  w_next[i] = w_trig[i] ? S_HOLD : S_IDLE;
            S_HOLD:  w_next[i] = w_rel[i]  ? S_IDLE : S_HOLD;
            default: w_next[i] = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_trig = '0;
      w_rel  = '0;
      w_busy = '0;
      for (int i = 0; i < NCH; i++) begin
         w_trig[i] = d[i] & ~mask_i[i] & (r_state[i] == S_IDLE);
         w_rel[i]  = (r_cnt[i] == '0) & (r_mode | ~d[i]);
         w_busy[i] = (r_state[i] == S_HOLD);
      end
   end

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < NCH; i++) begin
         w_pop = w_pop + CNTBITS'(r_q[i]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_dt   <= '0;
         r_mode <= 1'b0;
         r_q    <= '0;
         r_qcnt <= '0;
         for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
      end else begin
         r_dt   <= deadtime_i;
         r_mode <= mode_i;
         r_q    <= w_trig;
         r_qcnt <= w_pop;
         for (int i = 0; i < NCH; i++) begin
            if (w_trig[i])
               r_cnt[i] <= r_dt;
            else if (w_busy[i] && r_cnt[i] != '0)
               r_cnt[i] <= r_cnt[i] - 1'b1;
         end
      end
   end

   assign q     = r_q;
   assign busy  = w_busy;
   assign q_cnt = r_qcnt;

endmodule
